inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Fetch stage of the 3BC processor. Owns the program counter and drives the 10-bit address into the combinational instruction ROM.
- Registers the returned 9-bit instruction for decode, together with the PC it came from.
- Handles stall, taken branches through a writable branch-target LUT, program start and HALT detection.

Parameters:
ADDR_W, 10, PC / ROM address width
INST_W, 9, instruction width
START_ADDR, 0, PC value loaded on reset and on Start
LUT_DEPTH, 16, branch-target LUT entries (power of 2)
HALT_INST, 9'h1FF, encoding that ends the program

Ports:
Clk  input  1  clock, rising edge
Reset_n  input  1  asynchronous, active-low reset
Start  input  1  one-cycle pulse; begins execution from START_ADDR
Stall  input  1  hold the fetch stage (PC, Inst, InstValid frozen)
BranchTaken  input  1  decode/execute resolved a taken branch this cycle
TargetIdx  input  log2(LUT_DEPTH)  LUT index selecting the branch target
LutWrEn  input  1  write enable for the branch-target LUT
LutWrIdx  input  log2(LUT_DEPTH)  LUT write index
LutWrData  input  ADDR_W  LUT write data (absolute target address)
InstAddress  output  ADDR_W  ROM read address; always equals PC (combinational)
InstIn  input  INST_W  ROM data; combinational function of InstAddress
Inst  output  INST_W  registered instruction for decode
InstPC  output  ADDR_W  address Inst was fetched from
InstValid  output  1  Inst is a valid, non-squashed instruction
Done  output  1  program halted

Behaviour:
- States are IDLE, FETCH and HALTED. Reset (async, Reset_n=0) gives:
  - state=IDLE, PC=START_ADDR, Inst=0, InstPC=0, InstValid=0, Done=0.
  - All LUT entries = 0.
- IDLE: PC held; InstValid=0. Start -> FETCH with PC=START_ADDR.
- FETCH, Stall=1: every register holds, and InstValid holds its value. BranchTaken and Start are ignored; downstream holds BranchTaken until Stall drops.
- FETCH, Stall=0, BranchTaken=1:
  - PC <= LUT[TargetIdx].
  - InstValid <= 0; the ROM word fetched this cycle is wrong-path and is squashed.
  - Halt detection is suppressed this cycle.
  - One bubble per taken branch.
- FETCH, Stall=0, BranchTaken=0, InstIn==HALT_INST:
  - state <= HALTED, Done <= 1, InstValid <= 0.
  - PC holds, so HALT is never issued to decode.
- FETCH, Stall=0, otherwise: Inst <= InstIn, InstPC <= PC, InstValid <= 1, PC <= PC+1.
  - Fetch latency is 1 cycle: the word at address A appears on Inst the cycle after PC=A.
- PC increment wraps modulo 2^ADDR_W: 0x3FF -> 0x000, with no flag.
- HALTED: Done=1, InstValid=0, PC frozen. Start -> FETCH, PC=START_ADDR, Done <= 0.
- Start in FETCH is ignored.
- LUT:
  - Written synchronously in any state (not gated by Stall).
  - Read is combinational.
  - Write and read of the same index in the same cycle: the read returns the old value.
- Reset mid-program: immediate return to reset values, including the LUT.

Optional Feature:
INST_FETCH_COUNT_EN
- Defined: adds output InstCount [15:0].
  - Increments on every cycle where InstValid is loaded with 1.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by reset and by Start.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset, Start, ROM[0..3]=9'h001,002,003,1FF -> Inst=001,002,003 with InstPC=0,1,2 on consecutive cycles; the cycle after, Done=1, InstValid=0, PC=3.
- LUT[5]=0x040, ROM[0x040]=9'h0AA; BranchTaken with TargetIdx=5 while PC=2 -> next cycle InstValid=0, PC=0x040; following cycle Inst=0AA, InstPC=0x040.
- Stall=1 for 3 cycles at PC=7 with BranchTaken=1 -> PC=7, Inst and InstValid unchanged throughout; the branch takes effect in the first cycle after Stall=0.
- ROM[9]=9'h1FF with BranchTaken to LUT[1]=0x010 in the same cycle PC=9 -> no halt, Done=0, PC=0x010.
- PC=0x3FF, no branch, ROM[0x3FF]=9'h011 -> Inst=011, InstPC=0x3FF, PC=0x000; a same-cycle LUT write/read of index 3 returns the old target.
- Reset_n asserted mid-FETCH at PC=0x123 -> outputs return to reset values asynchronously, state=IDLE; in HALTED, Start restarts at START_ADDR (InstCount=0 when the macro is defined).

Source files
------------

// File: rtl/inst_fetch.sv
// Fetch stage of the 3BC processor: owns the PC, registers ROM words for decode,
// resolves taken branches through a writable target LUT and detects HALT.
// Optional build macro INST_FETCH_COUNT_EN adds a saturating InstCount output.
module inst_fetch #(
  parameter int                ADDR_W     = 10,
  parameter int                INST_W     = 9,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter int                LUT_DEPTH  = 16,
  parameter logic [INST_W-1:0] HALT_INST  = 9'h1FF,
  localparam int               IDX_W      = $clog2(LUT_DEPTH)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Stall,
  input  logic              BranchTaken,
  input  logic [IDX_W-1:0]  TargetIdx,
  input  logic              LutWrEn,
  input  logic [IDX_W-1:0]  LutWrIdx,
  input  logic [ADDR_W-1:0] LutWrData,
  output logic [ADDR_W-1:0] InstAddress,
  input  logic [INST_W-1:0] InstIn,
  output logic [INST_W-1:0] Inst,
  output logic [ADDR_W-1:0] InstPC,
  output logic              InstValid,
`ifdef INST_FETCH_COUNT_EN
  output logic [15:0]       InstCount,
`endif
  output logic              Done,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   lut_q [LUT_DEPTH];
  logic [ADDR_W-1:0]   lut_d [LUT_DEPTH];
  logic                issue;
  logic                start_acc;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    done_d    = done_q;
    issue     = 1'b0;
    start_acc = 1'b0;
    lut_d     = lut_q;
    // LUT writes ignore Stall; reads below use lut_q, so same-index read sees the old entry
    if (LutWrEn) lut_d[LutWrIdx] = LutWrData;

    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (Start) begin
          state_d   = ST_FETCH;
          pc_d      = START_ADDR;
          start_acc = 1'b1;
        end
      end
      ST_FETCH: begin
        if (!Stall) begin
          if (BranchTaken) begin
            pc_d    = lut_q[TargetIdx];
            valid_d = 1'b0;
          end else if (InstIn == HALT_INST) begin
            // PC stays on the HALT word so it never reaches decode
            state_d = ST_HALTED;
            done_d  = 1'b1;
            valid_d = 1'b0;
          end else begin
            inst_d    = InstIn;
            inst_pc_d = pc_q;
            valid_d   = 1'b1;
            pc_d      = pc_q + 1'b1;
            issue     = 1'b1;
          end
        end
      end
      ST_HALTED: begin
        valid_d = 1'b0;
        done_d  = 1'b1;
        if (Start) begin
          state_d   = ST_FETCH;
          pc_d      = START_ADDR;
          done_d    = 1'b0;
          start_acc = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= START_ADDR;
      inst_q    <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < LUT_DEPTH; i++) lut_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      lut_q     <= lut_d;
    end
  end

`ifdef INST_FETCH_COUNT_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (start_acc)                          count_d = '0;
    else if (issue && count_q != 16'hFFFF)  count_d = count_q + 16'd1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign InstCount = count_q;
`else
  logic unused_ok;
  assign unused_ok = issue ^ start_acc;
`endif

  assign InstAddress = pc_q;
  assign Inst        = inst_q;
  assign InstPC      = inst_pc_q;
  assign InstValid   = valid_q;
  assign Done        = done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a behavioural ROM array feeds InstIn and each
// scenario task checks hand-computed PC / Inst / InstValid / Done values.
module tb_inst_fetch;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       Start, Stall, BranchTaken, LutWrEn;
  logic [3:0] TargetIdx, LutWrIdx;
  logic [9:0] LutWrData;
  logic [9:0] InstAddress;
  logic [8:0] InstIn;
  logic [8:0] Inst;
  logic [9:0] InstPC;
  logic       InstValid, Done;
  logic [1:0] dbg_state;
`ifdef INST_FETCH_COUNT_EN
  logic [15:0] InstCount;
`endif

  logic [8:0] rom [0:1023];
  int n_checks = 0;
  int n_fail   = 0;

  assign InstIn = rom[InstAddress];

  inst_fetch dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall),
    .BranchTaken(BranchTaken), .TargetIdx(TargetIdx),
    .LutWrEn(LutWrEn), .LutWrIdx(LutWrIdx), .LutWrData(LutWrData),
    .InstAddress(InstAddress), .InstIn(InstIn), .Inst(Inst), .InstPC(InstPC),
    .InstValid(InstValid),
`ifdef INST_FETCH_COUNT_EN
    .InstCount(InstCount),
`endif
    .Done(Done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  // advance one rising edge, then settle 1 time unit before driving/sampling
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic lut_write(input logic [3:0] idx, input logic [9:0] data);
    LutWrEn = 1'b1; LutWrIdx = idx; LutWrData = data;
    step();
    LutWrEn = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; Start = 0; Stall = 0; BranchTaken = 0; LutWrEn = 0;
    TargetIdx = 0; LutWrIdx = 0; LutWrData = 0;
    for (int i = 0; i < 1024; i++) rom[i] = {1'b0, i[7:0]};
    step(); step();
    if (InstAddress !== 10'h000) begin n_fail++; $display("FAIL rst_pc: got %h want 000", InstAddress); end n_checks++;
    if (Inst !== 9'h000 || InstPC !== 10'h000) begin n_fail++; $display("FAIL rst_inst: got %h/%h want 000/000", Inst, InstPC); end n_checks++;
    if (InstValid !== 1'b0 || Done !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got v=%b d=%b want 0/0", InstValid, Done); end n_checks++;
    if (dbg_state !== S_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want %0d", dbg_state, S_IDLE); end n_checks++;
    Reset_n = 1'b1;
    step(); step();
    if (InstAddress !== 10'h000 || InstValid !== 1'b0 || dbg_state !== S_IDLE) begin
      n_fail++; $display("FAIL idle_hold: got pc=%h v=%b st=%0d want 000/0/%0d", InstAddress, InstValid, dbg_state, S_IDLE);
    end n_checks++;
  endtask

  task automatic test_halt();
    logic [8:0] exp_inst [3];
    exp_inst[0] = 9'h001; exp_inst[1] = 9'h002; exp_inst[2] = 9'h003;
    rom[0] = 9'h001; rom[1] = 9'h002; rom[2] = 9'h003; rom[3] = 9'h1FF;
    pulse_start();
    if (dbg_state !== S_FETCH || InstValid !== 1'b0 || InstAddress !== 10'h000) begin
      n_fail++; $display("FAIL start_fetch: got st=%0d v=%b pc=%h want %0d/0/000", dbg_state, InstValid, InstAddress, S_FETCH);
    end n_checks++;
    for (int k = 0; k < 3; k++) begin
      step();
      if (Inst !== exp_inst[k] || InstPC !== 10'(k) || InstValid !== 1'b1) begin
        n_fail++; $display("FAIL seq_fetch%0d: got %h@%h v=%b want %h@%h v=1", k, Inst, InstPC, InstValid, exp_inst[k], 10'(k));
      end n_checks++;
    end
    step();
    if (Done !== 1'b1 || InstValid !== 1'b0 || InstAddress !== 10'h003 || dbg_state !== S_HALTED) begin
      n_fail++; $display("FAIL halt: got d=%b v=%b pc=%h st=%0d want 1/0/003/%0d", Done, InstValid, InstAddress, dbg_state, S_HALTED);
    end n_checks++;
    step();
    if (Done !== 1'b1 || InstAddress !== 10'h003 || Inst !== 9'h003) begin
      n_fail++; $display("FAIL halt_hold: got d=%b pc=%h inst=%h want 1/003/003", Done, InstAddress, Inst);
    end n_checks++;
  endtask

  task automatic test_branch();
    lut_write(4'd5, 10'h040);
    rom[10'h040] = 9'h0AA;
    pulse_start();
    if (Done !== 1'b0 || InstAddress !== 10'h000) begin n_fail++; $display("FAIL restart: got d=%b pc=%h want 0/000", Done, InstAddress); end n_checks++;
    step(); step();
    BranchTaken = 1'b1; TargetIdx = 4'd5;
    step();
    BranchTaken = 1'b0;
    if (InstValid !== 1'b0 || InstAddress !== 10'h040 || Inst !== 9'h002) begin
      n_fail++; $display("FAIL br_bubble: got v=%b pc=%h inst=%h want 0/040/002", InstValid, InstAddress, Inst);
    end n_checks++;
    step();
    if (Inst !== 9'h0AA || InstPC !== 10'h040 || InstValid !== 1'b1 || InstAddress !== 10'h041) begin
      n_fail++; $display("FAIL br_target: got %h@%h v=%b pc=%h want 0aa@040 v=1 pc=041", Inst, InstPC, InstValid, InstAddress);
    end n_checks++;
  endtask

  task automatic test_stall_and_halt_squash();
    lut_write(4'd2, 10'h006);
    lut_write(4'd4, 10'h009);
    lut_write(4'd1, 10'h010);
    rom[9] = 9'h1FF;
    BranchTaken = 1'b1; TargetIdx = 4'd2;
    step();
    BranchTaken = 1'b0;
    step();
    if (InstAddress !== 10'h007 || Inst !== 9'h006 || InstValid !== 1'b1) begin
      n_fail++; $display("FAIL pre_stall: got pc=%h inst=%h v=%b want 007/006/1", InstAddress, Inst, InstValid);
    end n_checks++;
    Stall = 1'b1; BranchTaken = 1'b1; TargetIdx = 4'd4;
    for (int k = 0; k < 3; k++) begin
      Start = (k == 1);
      step();
      if (InstAddress !== 10'h007 || Inst !== 9'h006 || InstPC !== 10'h006 || InstValid !== 1'b1) begin
        n_fail++; $display("FAIL stall%0d: got pc=%h inst=%h@%h v=%b want 007/006@006/1", k, InstAddress, Inst, InstPC, InstValid);
      end n_checks++;
    end
    Start = 1'b0; Stall = 1'b0;
    step();
    if (InstAddress !== 10'h009 || InstValid !== 1'b0) begin
      n_fail++; $display("FAIL stall_release: got pc=%h v=%b want 009/0", InstAddress, InstValid);
    end n_checks++;
    TargetIdx = 4'd1;
    step();
    BranchTaken = 1'b0;
    if (Done !== 1'b0 || InstAddress !== 10'h010 || dbg_state !== S_FETCH || InstValid !== 1'b0) begin
      n_fail++; $display("FAIL halt_squash: got d=%b pc=%h st=%0d v=%b want 0/010/%0d/0", Done, InstAddress, dbg_state, InstValid, S_FETCH);
    end n_checks++;
    step();
    if (Inst !== 9'h010 || InstPC !== 10'h010 || InstValid !== 1'b1) begin
      n_fail++; $display("FAIL after_squash: got %h@%h v=%b want 010@010 v=1", Inst, InstPC, InstValid);
    end n_checks++;
  endtask

  task automatic test_wrap_and_lut_rw();
    rom[10'h3FF] = 9'h011;
    lut_write(4'd3, 10'h3FF);
    BranchTaken = 1'b1; TargetIdx = 4'd3;
    LutWrEn = 1'b1; LutWrIdx = 4'd3; LutWrData = 10'h200;
    step();
    BranchTaken = 1'b0; LutWrEn = 1'b0;
    if (InstAddress !== 10'h3FF) begin n_fail++; $display("FAIL lut_old_read: got %h want 3ff", InstAddress); end n_checks++;
    step();
    if (Inst !== 9'h011 || InstPC !== 10'h3FF || InstAddress !== 10'h000 || InstValid !== 1'b1) begin
      n_fail++; $display("FAIL wrap: got %h@%h pc=%h v=%b want 011@3ff pc=000 v=1", Inst, InstPC, InstAddress, InstValid);
    end n_checks++;
    BranchTaken = 1'b1; TargetIdx = 4'd3;
    step();
    BranchTaken = 1'b0;
    if (InstAddress !== 10'h200) begin n_fail++; $display("FAIL lut_new_read: got %h want 200", InstAddress); end n_checks++;
  endtask

  task automatic test_reset_mid_and_restart();
    lut_write(4'd6, 10'h123);
    BranchTaken = 1'b1; TargetIdx = 4'd6;
    step();
    BranchTaken = 1'b0;
    step();
    if (InstAddress !== 10'h124 || InstValid !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: got pc=%h v=%b want 124/1", InstAddress, InstValid);
    end n_checks++;
    #3 Reset_n = 1'b0;
    #1;
    if (InstAddress !== 10'h000 || Inst !== 9'h000 || InstPC !== 10'h000 || InstValid !== 1'b0 || Done !== 1'b0 || dbg_state !== S_IDLE) begin
      n_fail++; $display("FAIL async_reset: got pc=%h inst=%h@%h v=%b d=%b st=%0d want all zero, IDLE", InstAddress, Inst, InstPC, InstValid, Done, dbg_state);
    end n_checks++;
    step();
    Reset_n = 1'b1;
    pulse_start();
    BranchTaken = 1'b1; TargetIdx = 4'd6;
    step();
    BranchTaken = 1'b0;
    if (InstAddress !== 10'h000) begin n_fail++; $display("FAIL lut_cleared: got %h want 000", InstAddress); end n_checks++;
    step(); step(); step(); step();
    if (Done !== 1'b1 || InstAddress !== 10'h003) begin n_fail++; $display("FAIL halt2: got d=%b pc=%h want 1/003", Done, InstAddress); end n_checks++;
`ifdef INST_FETCH_COUNT_EN
    if (InstCount !== 16'd3) begin n_fail++; $display("FAIL count_halt: got %0d want 3", InstCount); end n_checks++;
`endif
    pulse_start();
    if (Done !== 1'b0 || InstAddress !== 10'h000 || dbg_state !== S_FETCH || InstValid !== 1'b0) begin
      n_fail++; $display("FAIL halted_restart: got d=%b pc=%h st=%0d v=%b want 0/000/%0d/0", Done, InstAddress, dbg_state, InstValid, S_FETCH);
    end n_checks++;
`ifdef INST_FETCH_COUNT_EN
    if (InstCount !== 16'd0) begin n_fail++; $display("FAIL count_clear: got %0d want 0", InstCount); end n_checks++;
`endif
  endtask

  initial begin
    test_reset();
    test_halt();
    test_branch();
    test_stall_and_halt_squash();
    test_wrap_and_lut_rw();
    test_reset_mid_and_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
